// File: rtl/fsm_cmd_pkg.sv
// Command codes and FSM state type shared by the button conditioner and the display FSM.
package fsm_cmd_pkg;

  localparam int NUM_KEYS = 3;

  // Key index order inside every {clear,back,fwd} vector.
  localparam int KEY_FWD   = 0;
  localparam int KEY_BACK  = 1;
  localparam int KEY_CLEAR = 2;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_BACK  = 2'b10;
  localparam logic [1:0] CMD_BLANK = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Clear wins outright; fwd and back together cancel into a blank.
  function automatic logic [1:0] press_code(input logic [NUM_KEYS-1:0] press);
    logic [1:0] code;
    code = CMD_HOLD;
    if (press[KEY_CLEAR])                        code = CMD_BLANK;
    else if (press[KEY_FWD] && press[KEY_BACK])  code = CMD_BLANK;
    else if (press[KEY_FWD])                     code = CMD_FWD;
    else if (press[KEY_BACK])                    code = CMD_BACK;
    return code;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// One key: two-flop synchroniser, debounce counter, stable level and a registered press pulse.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             stable;
  logic             armed;
  logic [CNT_W-1:0] count;
  logic [1:0]       vld_pipe;

  // armed: the key must be seen released after reset before a press counts,
  // so a key held through reset release never issues a command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      armed       <= 1'b0;
      count       <= '0;
      vld_pipe    <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= ~key_n;
      sync2       <= sync1;
      vld_pipe    <= {vld_pipe[0], 1'b1};
      press_pulse <= 1'b0;
      if (vld_pipe[1] && !sync2) armed <= 1'b1;
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable      <= sync2;
        count       <= '0;
        press_pulse <= sync2 & armed;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/button_command_conditioner.sv
// Turns three raw active-low keys into one held command per press, consumed by tick.
module button_command_conditioner
  import fsm_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_fwd_n,
  input  logic       btn_back_n,
  input  logic       btn_clear_n,
  input  logic       tick,
  output logic [1:0] cmd,
  output logic       cmd_pending,
  output logic       overrun,
  output logic [2:0] btn_level
);

  logic [NUM_KEYS-1:0] press;
  logic [1:0]          code;
  state_t              state;

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key [NUM_KEYS-1:0] (
    .clk         (clk),
    .reset       (reset),
    .key_n       ({btn_clear_n, btn_back_n, btn_fwd_n}),
    .level       (btn_level),
    .press_pulse (press)
  );

  assign code = press_code(press);

  // cmd doubles as the held-code register: it is only non-zero while PENDING.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd         <= CMD_HOLD;
      cmd_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (|press) begin
            state       <= PENDING;
            cmd         <= code;
            cmd_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (|press) begin
            // With tick the old code is consumed this cycle, so nothing is lost.
            cmd     <= code;
            overrun <= ~tick;
          end else if (tick) begin
            state       <= IDLE;
            cmd         <= CMD_HOLD;
            cmd_pending <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cmd         <= CMD_HOLD;
          cmd_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_command_conditioner.sv
// Directed and random key/tick stimulus against a window-based behavioural model.
module tb_button_command_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_fwd_n = 1'b1, btn_back_n = 1'b1, btn_clear_n = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] cmd;
  logic       cmd_pending, overrun;
  logic [2:0] btn_level;

  int checks = 0;
  int errors = 0;

  button_command_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_fwd_n(btn_fwd_n), .btn_back_n(btn_back_n),
    .btn_clear_n(btn_clear_n), .tick(tick), .cmd(cmd), .cmd_pending(cmd_pending),
    .overrun(overrun), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: keys seen two edges late; a level flips once the last D samples all disagree with it.
  bit [2:0] s1, s2, m_level, m_press, armed;
  bit       win [3][$];
  int       vcnt;
  bit       m_pending, m_ovr;
  bit [1:0] m_code;

  task automatic m_reset();
    s1 = 0; s2 = 0; m_level = 0; m_press = 0; armed = 0; vcnt = 0;
    m_pending = 0; m_ovr = 0; m_code = 0;
    for (int i = 0; i < 3; i++) win[i].delete();
  endtask

  task automatic m_edge(input bit [2:0] raw, input bit tk);
    bit [2:0] np;
    bit [1:0] code;
    bit       all_diff;
    if (!reset) begin m_reset(); return; end
    if (m_press[2] || (m_press[0] && m_press[1])) code = 3;
    else if (m_press[0])                          code = 1;
    else                                          code = 2;
    m_ovr = 0;
    if (m_press != 0) begin
      m_ovr = m_pending && !tk;
      m_pending = 1;
      m_code = code;
    end else if (tk) m_pending = 0;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      if (vcnt >= 2 && !s2[i]) armed[i] = 1;
      win[i].push_back(s2[i]);
      if (win[i].size() > D) void'(win[i].pop_front());
      all_diff = (win[i].size() == D);
      foreach (win[i][j]) if (win[i][j] == m_level[i]) all_diff = 0;
      if (all_diff) begin
        m_level[i] = ~m_level[i];
        np[i] = m_level[i] && armed[i];
      end
    end
    m_press = np;
    s2 = s1;
    s1 = raw;
    if (vcnt < 2) vcnt++;
  endtask

  task automatic check_all();
    chk("cmd", cmd, m_pending ? m_code : 0);
    chk("pend", cmd_pending, m_pending);
    chk("ovr", overrun, m_ovr);
    chk("lvl", btn_level, m_level);
  endtask

  // raw: 1 = pressed, bit order {clear,back,fwd}
  task automatic cyc(input bit [2:0] raw, input bit tk);
    {btn_clear_n, btn_back_n, btn_fwd_n} = ~raw;
    tick = tk;
    @(posedge clk);
    m_edge(raw, tk);
    #1;
    check_all();
  endtask

  task automatic async_reset(input bit [2:0] raw, input int n);
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_cmd", cmd, 0);
    chk("rst_pend", cmd_pending, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_lvl", btn_level, 0);
    repeat (n) cyc(raw, 0);
    reset = 1'b1;
  endtask

  int lat, rises, ovr_cnt, pend_cnt;
  bit prev_l;
  bit [2:0] keys;

  initial begin
    m_reset();
    // Keys held through reset and its release: no command may appear.
    {btn_clear_n, btn_back_n, btn_fwd_n} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    async_reset(3'b111, 3);
    pend_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(3'b111, i % 5 == 0);
      if (cmd_pending) pend_cnt++;
    end
    chk("held_at_reset", pend_cnt, 0);
    repeat (12) cyc(3'b000, 0);

    // Clean fwd press: pending exactly 6 edges after the first low sample.
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(3'b001, 0);
      if (lat < 0 && cmd_pending) lat = i;
    end
    chk("latency", lat, 2 + D);
    chk("fwd_cmd", cmd, 1);
    cyc(3'b001, 1);
    chk("fwd_consumed", cmd_pending, 0);
    repeat (10) cyc(3'b000, 0);

    // Bouncing back key: one rise, one command, no overrun.
    rises = 0; ovr_cnt = 0; prev_l = 0;
    for (int i = 0; i < 40; i++) begin
      cyc((i < 20) ? {1'b0, ((i / 2) % 2 == 0), 1'b0} : 3'b010, 0);
      if (btn_level[1] && !prev_l) rises++;
      prev_l = btn_level[1];
      if (overrun) ovr_cnt++;
    end
    chk("bounce_rises", rises, 1);
    chk("bounce_ovr", ovr_cnt, 0);
    chk("bounce_cmd", cmd, 2);
    cyc(3'b010, 1);
    repeat (12) cyc(3'b000, 0);

    // fwd then back 10 cycles later without tick: one overrun, back is consumed.
    ovr_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cyc((i < 10) ? 3'b001 : 3'b011, 0);
      if (overrun) ovr_cnt++;
    end
    chk("overrun_cnt", ovr_cnt, 1);
    chk("overrun_cmd", cmd, 2);
    cyc(3'b011, 1);
    repeat (12) cyc(3'b000, 0);

    // Same-cycle combinations.
    repeat (10) cyc(3'b011, 0);
    chk("fwd_back", cmd, 3);
    cyc(3'b011, 1);
    repeat (12) cyc(3'b000, 0);
    repeat (10) cyc(3'b101, 0);
    chk("clear_fwd", cmd, 3);
    repeat (12) cyc(3'b000, 1);

    // Reset while pending.
    repeat (10) cyc(3'b001, 0);
    chk("pre_reset_pend", cmd_pending, 1);
    async_reset(3'b001, 2);
    repeat (12) cyc(3'b000, 0);

    // Random keys, ticks and occasional resets.
    keys = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 7) == 0) keys[k] = ~keys[k];
      if ($urandom_range(0, 1499) == 0) async_reset(keys, $urandom_range(1, 3));
      else cyc(keys, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
